// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - Tuse/Tnew pending-write scoreboard and MDU busy timer for D-stage stall
//
// Purpose: per-register pending-write counters compared against operand Tuse
// decide whether the D-stage instruction can issue; an internal timer tracks
// multi-cycle mult/div occupancy of HI/LO.
// Optional feature macro: HAZARD_STATS_EN (adds stall_cycles / md_stall_cycles).
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   d_valid                        D stage holds a real instruction
//   d_rs, d_rt, d_rs_tuse, d_rt_tuse   source operands and their Tuse (all-ones = unused)
//   d_wr_en, d_wr_addr, d_tnew     destination write and its Tnew
//   d_md_start, d_md_is_div        mult/div start and latency select
//   d_md_use                       mfhi/mflo/mthi/mtlo
//   flush                          synchronous clear of the scoreboard
//   stall, issue, md_busy          hazard outputs
//   stall_cycles, md_stall_cycles  saturating counters (HAZARD_STATS_EN only)
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int TNEW_W   = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int MD_CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [TNEW_W-1:0] d_rs_tuse,
    input  logic [TNEW_W-1:0] d_rt_tuse,
    input  logic              d_wr_en,
    input  logic [REG_AW-1:0] d_wr_addr,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_md_start,
    input  logic              d_md_is_div,
    input  logic              d_md_use,
    input  logic              flush,
    output logic              stall,
    output logic              issue,
`ifdef HAZARD_STATS_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       md_stall_cycles,
`endif
    output logic              md_busy
);

    localparam int NREG = 2 ** REG_AW;
    localparam logic [MD_CNT_W-1:0] MULT_LAT_C = MD_CNT_W'(MULT_LAT);
    localparam logic [MD_CNT_W-1:0] DIV_LAT_C  = MD_CNT_W'(DIV_LAT);
    localparam logic [TNEW_W-1:0]   TUSE_NONE  = '1;

    logic [TNEW_W-1:0]   pend_q [NREG];
    logic [TNEW_W-1:0]   pend_d [NREG];
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic haz_rs, haz_rt, haz_md;

    // Hazard detection: purely combinational from current state and D inputs.
    always_comb begin
        haz_rs  = (d_rs != '0) && (d_rs_tuse != TUSE_NONE) && (pend_q[d_rs] > d_rs_tuse);
        haz_rt  = (d_rt != '0) && (d_rt_tuse != TUSE_NONE) && (pend_q[d_rt] > d_rt_tuse);
        md_busy = (md_cnt_q != '0);
        haz_md  = (d_md_start || d_md_use) && md_busy;
        stall   = d_valid && (haz_rs || haz_rt || haz_md);
        issue   = d_valid && !stall;
    end

    // Scoreboard next state: flush beats load, load beats decrement.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pend_d[r] = pend_q[r];
            if (flush) begin
                pend_d[r] = '0;
            end else if (issue && d_wr_en && (d_wr_addr != '0) && (d_wr_addr == REG_AW'(r))) begin
                pend_d[r] = d_tnew;
            end else if (pend_q[r] != '0) begin
                pend_d[r] = pend_q[r] - 1'b1;
            end
        end
        // Entry 0 is hardwired zero.
        pend_d[0] = '0;
    end

    // MDU timer is independent of flush: HI/LO results are already committed.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (issue && d_md_start) begin
            md_cnt_d = d_md_is_div ? DIV_LAT_C : MULT_LAT_C;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= '0;
            end
            md_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= pend_d[r];
            end
            md_cnt_q <= md_cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] md_stall_cycles_q, md_stall_cycles_d;

    always_comb begin
        stall_cycles_d    = stall_cycles_q;
        md_stall_cycles_d = md_stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (d_valid && haz_md && (md_stall_cycles_q != '1)) begin
            md_stall_cycles_d = md_stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q    <= '0;
            md_stall_cycles_q <= '0;
        end else begin
            stall_cycles_q    <= stall_cycles_d;
            md_stall_cycles_q <= md_stall_cycles_d;
        end
    end

    assign stall_cycles    = stall_cycles_q;
    assign md_stall_cycles = md_stall_cycles_q;
`endif

endmodule
